// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// alu_ctrl_pkg : shared decode types and constants for the EX-stage ALU
// Revision     : 1.0
// ============================================================================
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10,
    ALU_OP_OR    = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    CTRL_ADD = 3'd0,
    CTRL_SUB = 3'd1,
    CTRL_AND = 3'd2,
    CTRL_OR  = 3'd3,
    CTRL_SLT = 3'd4,
    CTRL_MUL = 3'd7
  } alu_ctrl_e;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  typedef logic [0:0] state_t;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_exec_mul_iter.sv
`default_nettype none
// ============================================================================
// mul_iter : iterative shift-add multiplier, one multiplier bit per cycle
// Revision : 1.0
// ============================================================================
module mul_iter #(
  parameter int DATA_W     = 32,
  parameter int MUL_SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic                  busy;
  logic [CNT_W-1:0]      count;
  logic [2*DATA_W-1:0]   acc;
  logic [2*DATA_W-1:0]   acc_next;
  logic [2*DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]     mplier;
  logic                  neg;
  logic [DATA_W-1:0]     mag_a;
  logic [DATA_W-1:0]     mag_b;
  logic                  start_neg;

  // Negating the most-negative value wraps to itself, which read as unsigned is
  // exactly its magnitude, so no extra width is needed here.
  generate
    if (MUL_SIGNED != 0) begin : g_signed
      assign mag_a     = a[DATA_W-1] ? -a : a;
      assign mag_b     = b[DATA_W-1] ? -b : b;
      assign start_neg = a[DATA_W-1] ^ b[DATA_W-1];
    end else begin : g_unsigned
      assign mag_a     = a;
      assign mag_b     = b;
      assign start_neg = 1'b0;
    end
  endgenerate

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (count == CNT_W'(DATA_W - 1));
  assign product  = neg ? -acc_next : acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (abort) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, mag_a};
      mplier <= mag_b;
      neg    <= start_neg;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_exec.sv
`default_nettype none
// ============================================================================
// alu_ctrl_exec : EX-stage ALU decode + execute with valid/ready handshakes
// Revision      : 1.0
// ============================================================================
module alu_ctrl_exec
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FUNCT_W    = 6,
  parameter int MUL_SIGNED = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [1:0]         ALU_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [DATA_W-1:0]  src1_i,
  input  logic [DATA_W-1:0]  src2_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [DATA_W-1:0]  result_o,
  output logic [DATA_W-1:0]  hi_o,
  output logic               zero_o,
  output logic [2:0]         ALU_Ctrl_o,
  output logic               illegal_o
);

  state_t                state;
  logic                  accept;
  alu_ctrl_e             dec_ctrl;
  logic                  dec_illegal;
  logic                  dec_mul;
  logic [DATA_W-1:0]     alu_res;
  logic                  mul_start;
  logic                  mul_done;
  logic [2*DATA_W-1:0]   mul_product;

  assign ready_o   = (state == ST_IDLE) && !flush_i && (!valid_o || ready_i);
  assign accept    = valid_i && ready_o;
  assign dec_mul   = (dec_ctrl == CTRL_MUL);
  assign mul_start = accept && dec_mul;
  assign zero_o    = (result_o == '0);

  always_comb begin
    dec_ctrl    = CTRL_ADD;
    dec_illegal = 1'b0;
    case (alu_op_e'(ALU_op_i))
      ALU_OP_ADD: dec_ctrl = CTRL_ADD;
      ALU_OP_SUB: dec_ctrl = CTRL_SUB;
      ALU_OP_OR:  dec_ctrl = CTRL_OR;
      default: begin
        case (funct_i)
          FUNCT_W'(FUNCT_ADD):  dec_ctrl = CTRL_ADD;
          FUNCT_W'(FUNCT_SUB):  dec_ctrl = CTRL_SUB;
          FUNCT_W'(FUNCT_AND):  dec_ctrl = CTRL_AND;
          FUNCT_W'(FUNCT_OR):   dec_ctrl = CTRL_OR;
          FUNCT_W'(FUNCT_SLT):  dec_ctrl = CTRL_SLT;
          FUNCT_W'(FUNCT_MULT): dec_ctrl = CTRL_MUL;
          default: begin
            dec_ctrl    = CTRL_ADD;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res = src1_i + src2_i;
    case (dec_ctrl)
      CTRL_SUB: alu_res = src1_i - src2_i;
      CTRL_AND: alu_res = src1_i & src2_i;
      CTRL_OR:  alu_res = src1_i | src2_i;
      CTRL_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      default:  alu_res = src1_i + src2_i;
    endcase
  end

  mul_iter #(
    .DATA_W     (DATA_W),
    .MUL_SIGNED (MUL_SIGNED)
  ) u_mul_iter (
    .clk     (clk_i),
    .rst     (rst_i),
    .abort   (flush_i),
    .start   (mul_start),
    .a       (src1_i),
    .b       (src2_i),
    .done    (mul_done),
    .product (mul_product)
  );

  // Accepting any op implies the previous result drains this cycle, so a
  // multiply start may drop valid_o unconditionally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      valid_o    <= 1'b0;
      result_o   <= '0;
      hi_o       <= '0;
      ALU_Ctrl_o <= 3'd0;
      illegal_o  <= 1'b0;
    end else if (flush_i) begin
      state   <= ST_IDLE;
      valid_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (dec_mul) begin
              state   <= ST_MUL;
              valid_o <= 1'b0;
            end else begin
              result_o   <= alu_res;
              ALU_Ctrl_o <= dec_ctrl;
              illegal_o  <= dec_illegal;
              valid_o    <= 1'b1;
            end
          end else if (ready_i) begin
            valid_o <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state      <= ST_IDLE;
            hi_o       <= mul_product[2*DATA_W-1:DATA_W];
            result_o   <= mul_product[DATA_W-1:0];
            ALU_Ctrl_o <= CTRL_MUL;
            illegal_o  <= 1'b0;
            valid_o    <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_exec.sv
`default_nettype none
// ============================================================================
// tb_alu_ctrl_exec : directed + random bench for signed and unsigned builds
// Revision         : 1.0
// ============================================================================
module tb_alu_ctrl_exec;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i, flush_i, valid_i, ready_i;
  logic [1:0]   ALU_op_i;
  logic [5:0]   funct_i;
  logic [W-1:0] src1_i, src2_i;

  logic         ready_s, valid_s, zero_s, illegal_s;
  logic [W-1:0] result_s, hi_s;
  logic [2:0]   ctrl_s;
  logic         ready_u, valid_u, zero_u, illegal_u;
  logic [W-1:0] result_u, hi_u;
  logic [2:0]   ctrl_u;

  always #5 clk = ~clk;

  alu_ctrl_exec #(.DATA_W(W), .FUNCT_W(6), .MUL_SIGNED(1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_s),
    .ALU_op_i(ALU_op_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
    .valid_o(valid_s), .ready_i(ready_i), .result_o(result_s), .hi_o(hi_s),
    .zero_o(zero_s), .ALU_Ctrl_o(ctrl_s), .illegal_o(illegal_s)
  );

  alu_ctrl_exec #(.DATA_W(W), .FUNCT_W(6), .MUL_SIGNED(0)) u_dut_u (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_u),
    .ALU_op_i(ALU_op_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
    .valid_o(valid_u), .ready_i(ready_i), .result_o(result_u), .hi_o(hi_u),
    .zero_o(zero_u), .ALU_Ctrl_o(ctrl_u), .illegal_o(illegal_u)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: expected output registers plus cycles left on a multiply.
  logic         m_valid, m_ill;
  logic [2:0]   m_ctrl;
  logic [W-1:0] m_res, m_res_u, m_hi, m_hi_u;
  logic [63:0]  m_pend_s, m_pend_u;
  int           m_mul_left;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_op(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, output bit is_mul, output logic [2:0] ctrl,
                        output bit ill, output logic [31:0] res,
                        output logic [63:0] ps, output logic [63:0] pu);
    is_mul = 0; ill = 0; ctrl = 3'd0;
    case (op)
      2'b00: ctrl = 3'd0;
      2'b01: ctrl = 3'd1;
      2'b11: ctrl = 3'd3;
      default: begin
        case (f)
          6'b100000: ctrl = 3'd0;
          6'b100010: ctrl = 3'd1;
          6'b100100: ctrl = 3'd2;
          6'b100101: ctrl = 3'd3;
          6'b101010: ctrl = 3'd4;
          6'b011000: begin ctrl = 3'd7; is_mul = 1; end
          default:   begin ctrl = 3'd0; ill = 1; end
        endcase
      end
    endcase
    case (ctrl)
      3'd1:    res = a - b;
      3'd2:    res = a & b;
      3'd3:    res = a | b;
      3'd4:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = a + b;
    endcase
    ps = 64'(longint'($signed(a)) * longint'($signed(b)));
    pu = {32'd0, a} * {32'd0, b};
  endtask

  task automatic model_reset();
    m_valid = 0; m_ill = 0; m_ctrl = 3'd0; m_res = '0; m_res_u = '0;
    m_hi = '0; m_hi_u = '0; m_mul_left = 0; m_pend_s = '0; m_pend_u = '0;
  endtask

  task automatic model_edge();
    bit is_mul, ill;
    logic [2:0] c;
    logic [31:0] r;
    logic [63:0] ps, pu;
    ref_op(ALU_op_i, funct_i, src1_i, src2_i, is_mul, c, ill, r, ps, pu);
    if (flush_i) begin
      m_valid = 0;
      m_mul_left = 0;
    end else if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin
        m_res = m_pend_s[31:0]; m_hi = m_pend_s[63:32];
        m_res_u = m_pend_u[31:0]; m_hi_u = m_pend_u[63:32];
        m_ctrl = 3'd7; m_ill = 0; m_valid = 1;
      end
    end else if (valid_i && (!m_valid || ready_i)) begin
      if (is_mul) begin
        m_pend_s = ps; m_pend_u = pu; m_mul_left = W; m_valid = 0;
      end else begin
        m_res = r; m_res_u = r; m_ctrl = c; m_ill = ill; m_valid = 1;
      end
    end else if (ready_i) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    check("valid_s", valid_s, m_valid);
    check("valid_u", valid_u, m_valid);
    if (m_valid) begin
      check("result_s", result_s, m_res);
      check("result_u", result_u, m_res_u);
      check("ctrl_s", ctrl_s, m_ctrl);
      check("ctrl_u", ctrl_u, m_ctrl);
      check("illegal_s", illegal_s, m_ill);
      check("zero_s", zero_s, m_res == '0);
      check("zero_u", zero_u, m_res_u == '0);
    end
    check("hi_s", hi_s, m_hi);
    check("hi_u", hi_u, m_hi_u);
  endtask

  task automatic do_cycle(input logic v, input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic r, input logic fl);
    valid_i = v; ALU_op_i = op; funct_i = f; src1_i = a; src2_i = b;
    ready_i = r; flush_i = fl;
    #1;
    check("ready_s", ready_s, (m_mul_left == 0) && !fl && (!m_valid || r));
    check("ready_u", ready_u, (m_mul_left == 0) && !fl && (!m_valid || r));
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    do_cycle(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    int n;
    do_cycle(1'b1, 2'b10, 6'b011000, a, b, 1'b1, 1'b0);
    n = 1;
    while (!valid_s && n < 100) begin
      idle();
      n++;
    end
    check("mul_latency", n, W + 1);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] fsel [7];
    logic [5:0] f;
    fsel[0] = 6'b100000; fsel[1] = 6'b100010; fsel[2] = 6'b100100; fsel[3] = 6'b100101;
    fsel[4] = 6'b101010; fsel[5] = 6'b011000; fsel[6] = 6'b111111;

    rst_i = 1; flush_i = 0; valid_i = 0; ready_i = 1; ALU_op_i = 0; funct_i = 0;
    src1_i = 0; src2_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid_s, 1'b0);
    check("rst_zero", zero_s, 1'b1);
    rst_i = 0;
    #1;
    check("rst_ready", ready_s, 1'b1);

    // Single-cycle decode cases
    do_cycle(1'b1, 2'b10, 6'b100010, 32'd0, 32'd1, 1'b1, 1'b0);
    check("sub_result", result_s, 32'hFFFF_FFFF);
    check("sub_ctrl", ctrl_s, 3'd1);
    check("sub_zero", zero_s, 1'b0);
    do_cycle(1'b1, 2'b10, 6'b101010, 32'hFFFF_FFFB, 32'd3, 1'b1, 1'b0);
    check("slt_result", result_s, 32'd1);
    do_cycle(1'b1, 2'b10, 6'b111111, 32'hFFFF_FFFB, 32'd3, 1'b1, 1'b0);
    check("illegal_result", result_s, 32'hFFFF_FFFE);
    check("illegal_flag", illegal_s, 1'b1);
    idle();

    // Multiplies, most-negative corner first, the -5*7 case last
    run_mul(32'h8000_0000, 32'hFFFF_FFFF);
    check("mneg_hi", hi_s, 32'h0000_0000);
    check("mneg_lo", result_s, 32'h8000_0000);
    run_mul(32'hFFFF_FFFF, 32'd2);
    check("umul_hi", hi_u, 32'd1);
    check("umul_lo", result_u, 32'hFFFF_FFFE);
    check("smul_hi", hi_s, 32'hFFFF_FFFF);
    run_mul(32'hFFFF_FFFB, 32'd7);
    check("mul_hi", hi_s, 32'hFFFF_FFFF);
    check("mul_lo", result_s, 32'hFFFF_FFDD);
    check("mul_ctrl", ctrl_s, 3'd7);
    idle();

    // Back-pressure on a single-cycle result
    do_cycle(1'b1, 2'b00, 6'd0, 32'd3, 32'd4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, 2'b00, 6'd0, 32'd10, 32'd20, 1'b0, 1'b0);
      check("bp_hold", result_s, 32'd7);
    end
    do_cycle(1'b1, 2'b00, 6'd0, 32'd10, 32'd20, 1'b1, 1'b0);
    check("bp_next", result_s, 32'd30);
    idle();

    // Flush on multiply cycle 10, with a competing valid_i
    do_cycle(1'b1, 2'b10, 6'b011000, 32'd5, 32'd6, 1'b1, 1'b0);
    repeat (9) idle();
    do_cycle(1'b1, 2'b00, 6'd0, 32'd1, 32'd1, 1'b1, 1'b1);
    check("flush_valid", valid_s, 1'b0);
    check("flush_hi", hi_s, 32'hFFFF_FFFF);
    flush_i = 0; valid_i = 0;
    #1;
    check("flush_ready", ready_s, 1'b1);
    repeat (40) idle();

    // Asynchronous reset on multiply cycle 20
    do_cycle(1'b1, 2'b10, 6'b011000, 32'd9, 32'd9, 1'b1, 1'b0);
    repeat (19) idle();
    #2;
    rst_i = 1;
    #1;
    check("arst_valid", valid_s, 1'b0);
    check("arst_result", result_s, 32'd0);
    check("arst_hi", hi_s, 32'd0);
    check("arst_ctrl", ctrl_s, 3'd0);
    check("arst_illegal", illegal_s, 1'b0);
    check("arst_zero", zero_s, 1'b1);
    model_reset();
    @(posedge clk);
    #1;
    rst_i = 0; valid_i = 0;
    #1;
    check("arst_ready", ready_s, 1'b1);
    repeat (40) idle();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      f = fsel[$urandom_range(0, 6)];
      if (f == 6'b111111) f = 6'($urandom);
      do_cycle(($urandom_range(0, 9) < 7), 2'($urandom), f, rand_word(), rand_word(),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
